// File: rtl/pkt_gate_pkg.sv
// pkt_gate_pkg: shared types and constants for the pkt_gate admission stage.
//   state_t    : gate FSM states
//   DROP_CNT_W : width of the optional dropped-packet counter
package pkt_gate_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DROP  = 3'd4
  } state_t;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/pkt_buf.sv
// pkt_buf: DEPTH x DWIDTH packet buffer (DEPTH = 2**AWIDTH), one synchronous
// write port and one combinational read port. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module pkt_buf
  import pkt_gate_pkg::*;
#(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2**AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pkt_gate.sv
// pkt_gate: admission stage in front of the packet sorter. Buffers one
// complete packet, filters malformed packets, and releases a buffered packet
// as a contiguous one-word-per-cycle burst only while the sorter is idle.
//   clk_i, srst_i          : clock, synchronous active-high reset
//   data_i/sop_i/eop_i     : upstream word, qualified by val_i
//   val_i, ready_o         : upstream handshake (transfer on val_i & ready_o)
//   busy_i                 : sorter busy flag
//   data_o/sop_o/eop_o     : registered burst to sorter, qualified by val_o
// Optional build macro PKT_GATE_DROP_CNT_EN adds drop_cnt_o, a saturating
// count of dropped packets.
module pkt_gate
  import pkt_gate_pkg::*;
#(
  parameter int unsigned AWIDTH       = 3,
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic              ready_o,
  input  logic              busy_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o
`ifdef PKT_GATE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int unsigned   DEPTH      = 2**AWIDTH;
  localparam logic [AWIDTH:0] FULL     = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [3:0]    GUARD_LOAD = 4'(GUARD_CYCLES);

  state_t            state, state_nxt;
  logic [AWIDTH:0]   count, count_nxt;
  logic [AWIDTH:0]   rd_ptr, rd_ptr_nxt;
  logic [3:0]        guard, guard_nxt;
  logic              val_nxt, sop_nxt, eop_nxt;
  logic [DWIDTH-1:0] data_nxt;

  logic              acc;
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;

  assign ready_o = (state == IDLE) || (state == FILL) || (state == DROP);
  assign acc     = val_i & ready_o;
  // WAIT presents word 0 so it can be registered on the WAIT->DRAIN edge.
  assign raddr   = (state == DRAIN) ? rd_ptr[AWIDTH-1:0] : '0;

  pkt_buf #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (data_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    guard_nxt  = (guard != '0) ? guard - 4'd1 : guard;
    val_nxt    = 1'b0;
    sop_nxt    = 1'b0;
    eop_nxt    = 1'b0;
    data_nxt   = data_o;
    we         = 1'b0;
    waddr      = '0;

    case (state)
      IDLE: begin
        if (acc && sop_i && !eop_i) begin
          we        = 1'b1;
          count_nxt = CNT_ONE;
          state_nxt = FILL;
        end
      end

      FILL: begin
        if (acc) begin
          if (sop_i) begin
            // Restart: partial packet is abandoned, new sop lands at address 0.
            if (eop_i) begin
              count_nxt = '0;
              state_nxt = IDLE;
            end else begin
              we        = 1'b1;
              count_nxt = CNT_ONE;
            end
          end else if (count == FULL) begin
            // One word past the buffer: an eop here ends the bad packet,
            // anything else must be swallowed until its eop.
            count_nxt = '0;
            state_nxt = eop_i ? IDLE : DROP;
          end else begin
            we        = 1'b1;
            waddr     = count[AWIDTH-1:0];
            count_nxt = count + CNT_ONE;
            if (eop_i) begin
              state_nxt = WAIT;
            end
          end
        end
      end

      DROP: begin
        if (acc && eop_i) begin
          state_nxt = IDLE;
        end
      end

      WAIT: begin
        if (!busy_i && (guard == '0)) begin
          state_nxt  = DRAIN;
          val_nxt    = 1'b1;
          sop_nxt    = 1'b1;
          eop_nxt    = (count == CNT_ONE);
          data_nxt   = rdata;
          rd_ptr_nxt = CNT_ONE;
        end
      end

      DRAIN: begin
        if (rd_ptr != count) begin
          val_nxt    = 1'b1;
          eop_nxt    = (rd_ptr == count - CNT_ONE);
          data_nxt   = rdata;
          rd_ptr_nxt = rd_ptr + CNT_ONE;
        end else begin
          // Current output cycle carries eop_o.
          state_nxt  = IDLE;
          count_nxt  = '0;
          rd_ptr_nxt = '0;
          guard_nxt  = GUARD_LOAD;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      guard  <= '0;
      val_o  <= 1'b0;
      sop_o  <= 1'b0;
      eop_o  <= 1'b0;
      data_o <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      guard  <= guard_nxt;
      val_o  <= val_nxt;
      sop_o  <= sop_nxt;
      eop_o  <= eop_nxt;
      data_o <= data_nxt;
    end
  end

`ifdef PKT_GATE_DROP_CNT_EN
  logic [1:0]            drop_inc;
  logic [DROP_CNT_W:0]   drop_sum;

  // A sop & eop word restarting a partial packet drops two packets at once.
  always_comb begin
    drop_inc = 2'd0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (sop_i && eop_i) drop_inc = 2'd1;
        end
        FILL: begin
          if (sop_i)              drop_inc = eop_i ? 2'd2 : 2'd1;
          else if (count == FULL) drop_inc = 2'd1;
        end
        default: begin
          drop_inc = 2'd0;
        end
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_cnt_o} + (DROP_CNT_W+1)'(drop_inc);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      drop_cnt_o <= '0;
    end else if (drop_inc != 2'd0) begin
      drop_cnt_o <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end
`endif

endmodule
